alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Sequential front-end for the combinational 16-bit ALU. Accepts one command per
//  valid/ready handshake, registers the operands and mode onto the ALU inputs, waits
//  SETTLE cycles, then captures Y/Cout/Overflow. Presents the captured result on a
//  valid/ready output port. Also keeps an accumulator, usable as operand A, and a
//  sticky overflow flag. Sits directly upstream of the ALU and drives all of its inputs.
// PARAMETERS
//  N       16  datapath width; equals the ALU width
//  M       4   mode width; equals the ALU Mode width
//  SETTLE  1   EXEC cycles allowed for the ALU to settle; legal range 1..15
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous reset, active-low
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  block can accept a command; equals (state==IDLE)
//  cmd_mode     in   M  ALU mode (0..15)
//  cmd_a        in   N  operand A, used when cmd_a_sel=0
//  cmd_b        in   N  operand B
//  cmd_cin      in   1  carry-in
//  cmd_a_sel    in   1  1: operand A taken from acc instead of cmd_a
//  cmd_wacc     in   1  1: write the result into acc at capture
//  alu_A        out  N  registered ALU operand A
//  alu_B        out  N  registered ALU operand B
//  alu_Cin      out  1  registered ALU carry-in
//  alu_Mode     out  M  registered ALU mode
//  alu_Y        in   N  ALU result
//  alu_Cout     in   1  ALU carry-out
//  alu_Overflow in   1  ALU overflow
//  res_valid    out  1  result available
//  res_ready    in   1  consumer takes the result
//  res_y        out  N  captured result
//  res_cout     out  1  captured carry-out; forced 0 unless mode is 4 or 5
//  res_ovf      out  1  captured overflow; forced 0 unless mode is 4 or 5
//  acc          out  N  accumulator
//  ovf_sticky   out  1  set by any captured res_ovf=1; cleared by clr_sticky
//  clr_sticky   in   1  synchronous clear of ovf_sticky
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately):
//   - state=IDLE; every output register = 0 (alu_*, res_*, acc, ovf_sticky)
//   - settle counter = 0
//   - reset mid-command aborts it with no result and no acc write
//  FSM states: IDLE, EXEC, DONE.
//   - IDLE -> EXEC on cmd_valid && cmd_ready. At that edge:
//       alu_A <= cmd_a_sel ? acc : cmd_a; alu_B <= cmd_b; alu_Cin <= cmd_cin;
//       alu_Mode <= cmd_mode. Latch wacc and the mode class internally; cnt <= 0.
//   - EXEC: cnt increments each cycle. On the edge where cnt == SETTLE-1:
//       capture alu_Y/alu_Cout/alu_Overflow into res_*; res_valid <= 1; go to DONE.
//       If wacc: acc <= alu_Y in the same edge.
//   - DONE -> IDLE on res_ready. At that edge res_valid <= 0.
//       res_* hold their value until the next capture.
//  alu_* change only on command acceptance; they stay stable through EXEC and DONE.
//  Latency: accept at edge T -> res_valid high from edge T+SETTLE.
//   - One command per SETTLE+2 cycles when res_ready is held high.
//  cmd_ready is low in EXEC and DONE, so no command is accepted while a result is pending.
//  cmd_a_sel=1 reads acc as it stands at the accept edge, i.e. after any earlier write.
//  Cout/Overflow masking: the ALU leaves these stale for modes other than 4/5,
//   so the sequencer forces res_cout=res_ovf=0 for every other mode.
//  ovf_sticky: set on a capture edge with res_ovf=1; cleared by clr_sticky.
//   - Set wins when clr_sticky and a capture with ovf=1 happen on the same edge.
//  Width: all datapaths are N bits; no extension or truncation is performed here.
// TESTING
//  1. Reset mid-EXEC: assert rst_n=0 during EXEC -> all outputs 0 at once, cmd_ready=1
//     after release, acc unchanged at 0.
//  2. Mode 4, A=16'h7FFF, B=16'h0001, Cin=0 -> res_y=16'h8000, res_ovf=1, ovf_sticky=1,
//     res_valid rises exactly SETTLE edges after accept.
//  3. Mode 6 (AND) right after a mode-4 overflow, ALU stub holding Cout/Overflow=1
//     -> res_cout=0 and res_ovf=0; ovf_sticky stays 1 until clr_sticky.
//  4. Accumulate chain: 16'h0003 wacc=1 (mode 14, B passthrough), then mode 4
//     a_sel=1 B=16'h0004 wacc=1 -> acc=16'h0007, alu_A=16'h0003 on the second op.
//  5. Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_y held,
//     cmd_ready=0, and a cmd_valid pulse is ignored.
//  6. Same edge clr_sticky=1 and capture with ovf=1 -> ovf_sticky=1; SETTLE=3 build
//     gives res_valid at accept+3 edges.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Sequential front-end for a combinational ALU.
// Accepts one command per cmd_valid/cmd_ready handshake, registers the operands
// onto the ALU inputs, waits SETTLE cycles, then captures the ALU outputs and
// presents them on a res_valid/res_ready port. Keeps an accumulator (optionally
// used as operand A) and a sticky overflow flag.
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   cmd_valid/cmd_ready                  command handshake
//   cmd_mode/a/b/cin/a_sel/wacc          command payload
//   alu_A/B/Cin/Mode                     registered ALU inputs
//   alu_Y/Cout/Overflow                  ALU outputs
//   res_valid/res_ready                  result handshake
//   res_y/res_cout/res_ovf               captured result
//   acc                                  accumulator
//   ovf_sticky, clr_sticky               sticky overflow and its clear
module alu_cmd_sequencer #(
    parameter int unsigned N      = 16,
    parameter int unsigned M      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [M-1:0] cmd_mode,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         cmd_cin,
    input  logic         cmd_a_sel,
    input  logic         cmd_wacc,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    output logic         alu_Cin,
    output logic [M-1:0] alu_Mode,
    input  logic [N-1:0] alu_Y,
    input  logic         alu_Cout,
    input  logic         alu_Overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_y,
    output logic         res_cout,
    output logic         res_ovf,
    output logic [N-1:0] acc,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);

    localparam int unsigned    CW       = 4;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
    localparam logic [M-1:0]   MODE_ADD = M'(4);
    localparam logic [M-1:0]   MODE_SUB = M'(5);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wacc_q, wacc_d;
    logic          arith_q, arith_d;
    logic [N-1:0]  alu_a_q, alu_a_d;
    logic [N-1:0]  alu_b_q, alu_b_d;
    logic          alu_cin_q, alu_cin_d;
    logic [M-1:0]  alu_mode_q, alu_mode_d;
    logic          res_valid_q, res_valid_d;
    logic [N-1:0]  res_y_q, res_y_d;
    logic          res_cout_q, res_cout_d;
    logic          res_ovf_q, res_ovf_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          sticky_q, sticky_d;

    // Ready is a pure decode of the state register.
    assign cmd_ready  = (state_q == IDLE);
    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_Cin    = alu_cin_q;
    assign alu_Mode   = alu_mode_q;
    assign res_valid  = res_valid_q;
    assign res_y      = res_y_q;
    assign res_cout   = res_cout_q;
    assign res_ovf    = res_ovf_q;
    assign acc        = acc_q;
    assign ovf_sticky = sticky_q;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wacc_d      = wacc_q;
        arith_d     = arith_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_mode_d  = alu_mode_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        acc_d       = acc_q;
        sticky_d    = clr_sticky ? 1'b0 : sticky_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d    = cmd_a_sel ? acc_q : cmd_a;
                    alu_b_d    = cmd_b;
                    alu_cin_d  = cmd_cin;
                    alu_mode_d = cmd_mode;
                    wacc_d     = cmd_wacc;
                    arith_d    = (cmd_mode == MODE_ADD) || (cmd_mode == MODE_SUB);
                    cnt_d      = '0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Cout/Overflow are only meaningful for add/subtract.
                    res_y_d     = alu_Y;
                    res_cout_d  = alu_Cout & arith_q;
                    res_ovf_d   = alu_Overflow & arith_q;
                    res_valid_d = 1'b1;
                    if (wacc_q) begin
                        acc_d = alu_Y;
                    end
                    // Set overrides a simultaneous clear.
                    if (alu_Overflow && arith_q) begin
                        sticky_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wacc_q      <= 1'b0;
            arith_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_mode_q  <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wacc_q      <= wacc_d;
            arith_q     <= arith_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_mode_q  <= alu_mode_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: one instance with SETTLE=1 and one
// with SETTLE=3, each driving a behavioural ALU stub that leaves Cout/Overflow
// high for non-arithmetic modes. Expected results are queued at command accept
// and compared when the result appears.
module tb_alu_cmd_sequencer;

    localparam int unsigned N = 16;
    localparam int unsigned M = 4;

    typedef struct packed {
        logic [N-1:0] y;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [M-1:0] cmd_mode;
    logic [N-1:0] cmd_a, cmd_b;
    logic         cmd_cin, cmd_a_sel, cmd_wacc;

    logic         cmd_valid  [2];
    logic         res_ready  [2];
    logic         clr_sticky [2];
    logic         cmd_ready  [2];
    logic [N-1:0] alu_A      [2];
    logic [N-1:0] alu_B      [2];
    logic         alu_Cin    [2];
    logic [M-1:0] alu_Mode   [2];
    logic [N-1:0] alu_Y      [2];
    logic         alu_Cout   [2];
    logic         alu_Ovf    [2];
    logic         res_valid  [2];
    logic [N-1:0] res_y      [2];
    logic         res_cout   [2];
    logic         res_ovf    [2];
    logic [N-1:0] acc        [2];
    logic         ovf_sticky [2];

    exp_t         exp_q[$];
    logic [N-1:0] acc_m    [2];
    logic         sticky_m [2];
    int           tests = 0;
    int           fails = 0;

    // ALU stub: returns {ovf, cout, y}; non-arith modes leave cout/ovf stale-high.
    function automatic logic [N+1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic cin, input logic [M-1:0] mode);
        logic [N:0]   s;
        logic [N-1:0] y;
        logic         c, v;
        c = 1'b1;
        v = 1'b1;
        case (mode)
            4'd4: begin
                s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
                y = s[N-1:0];
                c = s[N];
                v = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
            end
            4'd5: begin
                s = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, cin};
                y = s[N-1:0];
                c = s[N];
                v = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
            end
            4'd6:    y = a & b;
            4'd7:    y = a | b;
            4'd8:    y = a ^ b;
            4'd14:   y = b;
            default: y = a;
        endcase
        return {v, c, y};
    endfunction

    assign {alu_Ovf[0], alu_Cout[0], alu_Y[0]} = alu_model(alu_A[0], alu_B[0], alu_Cin[0], alu_Mode[0]);
    assign {alu_Ovf[1], alu_Cout[1], alu_Y[1]} = alu_model(alu_A[1], alu_B[1], alu_Cin[1], alu_Mode[1]);

    alu_cmd_sequencer #(.N(N), .M(M), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .cmd_a_sel(cmd_a_sel), .cmd_wacc(cmd_wacc),
        .alu_A(alu_A[0]), .alu_B(alu_B[0]), .alu_Cin(alu_Cin[0]), .alu_Mode(alu_Mode[0]),
        .alu_Y(alu_Y[0]), .alu_Cout(alu_Cout[0]), .alu_Overflow(alu_Ovf[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_y(res_y[0]), .res_cout(res_cout[0]), .res_ovf(res_ovf[0]),
        .acc(acc[0]), .ovf_sticky(ovf_sticky[0]), .clr_sticky(clr_sticky[0])
    );

    alu_cmd_sequencer #(.N(N), .M(M), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .cmd_a_sel(cmd_a_sel), .cmd_wacc(cmd_wacc),
        .alu_A(alu_A[1]), .alu_B(alu_B[1]), .alu_Cin(alu_Cin[1]), .alu_Mode(alu_Mode[1]),
        .alu_Y(alu_Y[1]), .alu_Cout(alu_Cout[1]), .alu_Overflow(alu_Ovf[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_y(res_y[1]), .res_cout(res_cout[1]), .res_ovf(res_ovf[1]),
        .acc(acc[1]), .ovf_sticky(ovf_sticky[1]), .clr_sticky(clr_sticky[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one command, wait for acceptance, queue the expected result.
    task automatic send_cmd(input int d, input logic [M-1:0] mode, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic cin, input logic asel,
                            input logic wacc);
        logic [N-1:0] opa;
        logic [N+1:0] r;
        logic         arith;
        int           wait_cyc;
        cmd_mode  = mode;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_a_sel = asel;
        cmd_wacc  = wacc;
        cmd_valid[d] = 1'b1;
        wait_cyc = 0;
        while (!cmd_ready[d] && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        tests++;
        if (cmd_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout dut%0d: cmd_ready=%b required 1", d, cmd_ready[d]);
        end
        tick();
        cmd_valid[d] = 1'b0;
        opa   = asel ? acc_m[d] : a;
        r     = alu_model(opa, b, cin, mode);
        arith = (mode == 4'd4) || (mode == 4'd5);
        exp_q.push_back('{y: r[N-1:0], cout: r[N] & arith, ovf: r[N+1] & arith});
        if (wacc) acc_m[d] = r[N-1:0];
        tests++;
        if ({alu_A[d], alu_B[d], alu_Cin[d], alu_Mode[d]} !== {opa, b, cin, mode}) begin
            fails++;
            $display("FAIL alu_inputs dut%0d: got A=%h B=%h Cin=%b Mode=%0d required A=%h B=%h Cin=%b Mode=%0d",
                     d, alu_A[d], alu_B[d], alu_Cin[d], alu_Mode[d], opa, b, cin, mode);
        end
    endtask

    // Wait for res_valid, check latency, pop and compare. Optionally raise
    // clr_sticky after sampling edge clr_edge.
    task automatic wait_result(input int d, input int exp_edges, input int clr_edge);
        int   edges;
        exp_t e;
        edges = 0;
        while (res_valid[d] !== 1'b1 && edges < 100) begin
            clr_sticky[d] = (edges == clr_edge);
            tick();
            edges++;
        end
        clr_sticky[d] = 1'b0;
        tests++;
        if (res_valid[d] !== 1'b1 || edges != exp_edges) begin
            fails++;
            $display("FAIL latency dut%0d: res_valid=%b after %0d edges required 1 after %0d",
                     d, res_valid[d], edges, exp_edges);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty dut%0d: result seen with 0 queued, required 1", d);
        end else begin
            e = exp_q.pop_front();
            if (e.ovf) sticky_m[d] = 1'b1;
            if ({res_y[d], res_cout[d], res_ovf[d]} !== {e.y, e.cout, e.ovf}) begin
                fails++;
                $display("FAIL result dut%0d: got y=%h cout=%b ovf=%b required y=%h cout=%b ovf=%b",
                         d, res_y[d], res_cout[d], res_ovf[d], e.y, e.cout, e.ovf);
            end
        end
        tests++;
        if (ovf_sticky[d] !== sticky_m[d] || acc[d] !== acc_m[d]) begin
            fails++;
            $display("FAIL sticky_acc dut%0d: got sticky=%b acc=%h required sticky=%b acc=%h",
                     d, ovf_sticky[d], acc[d], sticky_m[d], acc_m[d]);
        end
    endtask

    task automatic take_result(input int d);
        res_ready[d] = 1'b1;
        tick();
        res_ready[d] = 1'b0;
        tests++;
        if (res_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL take dut%0d: res_valid=%b cmd_ready=%b required 0 and 1",
                     d, res_valid[d], cmd_ready[d]);
        end
    endtask

    task automatic clear_sticky(input int d);
        clr_sticky[d] = 1'b1;
        tick();
        clr_sticky[d] = 1'b0;
        sticky_m[d] = 1'b0;
        tests++;
        if (ovf_sticky[d] !== 1'b0) begin
            fails++;
            $display("FAIL clr_sticky dut%0d: ovf_sticky=%b required 0", d, ovf_sticky[d]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({alu_A[d], alu_B[d], alu_Cin[d], alu_Mode[d], res_valid[d], res_y[d],
                 res_cout[d], res_ovf[d], acc[d], ovf_sticky[d], cmd_ready[d]} !==
                {{(3*N+M+5){1'b0}}, 1'b1}) begin
                fails++;
                $display("FAIL %s dut%0d: A=%h B=%h Mode=%0d rv=%b y=%h acc=%h sticky=%b rdy=%b required all 0, rdy=1",
                         tag, d, alu_A[d], alu_B[d], alu_Mode[d], res_valid[d], res_y[d],
                         acc[d], ovf_sticky[d], cmd_ready[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst_n = 1'b1;
        tick();
        // Abort a command mid-EXEC on the SETTLE=3 instance and on the SETTLE=1 one.
        send_cmd(1, 4'd4, 16'h1234, 16'h1111, 1'b1, 1'b0, 1'b1);
        void'(exp_q.pop_back());
        acc_m[1] = '0;
        tick();
        send_cmd(0, 4'd4, 16'h4321, 16'h0101, 1'b0, 1'b0, 1'b1);
        void'(exp_q.pop_back());
        acc_m[0] = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_exec");
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_all_zero("reset_no_result");
    endtask

    task automatic test_overflow();
        send_cmd(0, 4'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        wait_result(0, 1, -1);
        tests++;
        if (res_y[0] !== 16'h8000 || res_ovf[0] !== 1'b1 || ovf_sticky[0] !== 1'b1) begin
            fails++;
            $display("FAIL ovf_vector: y=%h ovf=%b sticky=%b required 8000 1 1",
                     res_y[0], res_ovf[0], ovf_sticky[0]);
        end
        take_result(0);
    endtask

    task automatic test_mask();
        send_cmd(0, 4'd6, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        wait_result(0, 1, -1);
        take_result(0);
        tests++;
        if (ovf_sticky[0] !== 1'b1) begin
            fails++;
            $display("FAIL sticky_hold: ovf_sticky=%b required 1", ovf_sticky[0]);
        end
        clear_sticky(0);
    endtask

    task automatic test_accumulate();
        send_cmd(0, 4'd14, 16'hDEAD, 16'h0003, 1'b0, 1'b0, 1'b1);
        wait_result(0, 1, -1);
        take_result(0);
        send_cmd(0, 4'd4, 16'hBEEF, 16'h0004, 1'b0, 1'b1, 1'b1);
        tests++;
        if (alu_A[0] !== 16'h0003) begin
            fails++;
            $display("FAIL acc_operand: alu_A=%h required 0003", alu_A[0]);
        end
        wait_result(0, 1, -1);
        take_result(0);
        tests++;
        if (acc[0] !== 16'h0007) begin
            fails++;
            $display("FAIL acc_chain: acc=%h required 0007", acc[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] held;
        send_cmd(0, 4'd8, 16'hA5A5, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        wait_result(0, 1, -1);
        held = 16'hA5A5 ^ 16'h0FF0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cmd_mode = 4'd4; cmd_a = 16'h0001; cmd_b = 16'h0001;
                cmd_a_sel = 1'b0; cmd_wacc = 1'b1;
                cmd_valid[0] = 1'b1;
            end else begin
                cmd_valid[0] = 1'b0;
            end
            tick();
            tests++;
            if (res_valid[0] !== 1'b1 || res_y[0] !== held || cmd_ready[0] !== 1'b0) begin
                fails++;
                $display("FAIL backpressure cycle %0d: rv=%b y=%h rdy=%b required 1 %h 0",
                         i, res_valid[0], res_y[0], cmd_ready[0], held);
            end
        end
        tests++;
        if (alu_A[0] !== 16'hA5A5 || alu_Mode[0] !== 4'd8) begin
            fails++;
            $display("FAIL ignored_cmd: alu_A=%h Mode=%0d required A5A5 8", alu_A[0], alu_Mode[0]);
        end
        take_result(0);
        repeat (4) tick();
        tests++;
        if (res_valid[0] !== 1'b0 || acc[0] !== acc_m[0]) begin
            fails++;
            $display("FAIL no_phantom: rv=%b acc=%h required 0 %h", res_valid[0], acc[0], acc_m[0]);
        end
    endtask

    task automatic test_back_to_back();
        time t_prev, t_now;
        res_ready[0] = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(0, (i % 2 == 0) ? 4'd5 : 4'd7, 16'h1000 + 16'(i * 16'h0111),
                     16'h0321 + 16'(i), 1'b1, 1'(i == 3), 1'(i >= 2));
            t_now = $time;
            if (i > 0) begin
                tests++;
                if (t_now - t_prev != 30) begin
                    fails++;
                    $display("FAIL throughput cmd %0d: spacing %0t required 30", i, t_now - t_prev);
                end
            end
            t_prev = t_now;
            wait_result(0, 1, -1);
        end
        res_ready[0] = 1'b0;
        tick();
    endtask

    task automatic test_same_edge();
        send_cmd(1, 4'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        wait_result(1, 3, 2);
        take_result(1);
        tests++;
        if (ovf_sticky[1] !== 1'b1) begin
            fails++;
            $display("FAIL set_wins: ovf_sticky=%b required 1", ovf_sticky[1]);
        end
        clear_sticky(1);
        send_cmd(1, 4'd5, 16'h0010, 16'h0003, 1'b1, 1'b0, 1'b1);
        wait_result(1, 3, -1);
        take_result(1);
    endtask

    initial begin
        cmd_mode = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_a_sel = 1'b0; cmd_wacc = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; res_ready[d] = 1'b0; clr_sticky[d] = 1'b0;
            acc_m[d] = '0; sticky_m[d] = 1'b0;
        end
        test_reset();
        test_overflow();
        test_mask();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_same_edge();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
